// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 2-flop input synchronizer, mid-bit sampling, valid/frame-error strobes.
// Optional build macro UART_RX_MAJORITY_VOTE_EN: data and stop bits are decided by a 2-of-3 majority vote.
module uart_rx #(
    parameter int p_CLKs_PB = 217
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Rx_UART,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Valid,
    output logic       o_Rx_Frame_Err,
    output logic       o_Rx_Busy
);
    localparam int cw = $clog2(p_CLKs_PB);
    localparam logic [cw-1:0] last_cnt = cw'(p_CLKs_PB - 1);
    localparam logic [cw-1:0] mid_cnt = cw'((p_CLKs_PB - 1) / 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    logic [cw-1:0]   count;
    logic [2:0]      index;
    logic [7:0]      shreg;
    logic            sync_a;
    logic            line;
    logic            prev;
    logic            bit_s;

    // bring the asynchronous pin into the clock domain and keep one cycle of history for edge detection
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            sync_a <= 1'b1;
            line   <= 1'b1;
            prev   <= 1'b1;
        end else begin
            sync_a <= i_Rx_UART;
            line   <= sync_a;
            prev   <= line;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0] votes;

    // the two line samples preceding the decision cycle, used as voters together with the current line
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            votes <= 2'b11;
        end else begin
            votes <= {votes[0], line};
        end
    end

    assign bit_s = (votes[1] & votes[0]) | (votes[1] & line) | (votes[0] & line);
`else
    assign bit_s = line;
`endif

    // framing state machine: start-bit qualification, eight data bits LSB first, stop-bit check
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state          <= IDLE;
            count          <= '0;
            index          <= 3'd0;
            shreg          <= 8'h00;
            o_Rx_Byte      <= 8'h00;
            o_Rx_Valid     <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
            o_Rx_Busy      <= 1'b0;
        end else begin
            o_Rx_Valid     <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
            case (state)
                IDLE: begin
                    if (prev && !line) begin
                        state     <= START;
                        count     <= '0;
                        index     <= 3'd0;
                        o_Rx_Busy <= 1'b1;
                    end
                end
                START: begin
                    if (count == mid_cnt) begin
                        count     <= '0;
                        state     <= line ? IDLE : DATA;
                        o_Rx_Busy <= !line;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DATA: begin
                    if (count == last_cnt) begin
                        shreg[index] <= bit_s;
                        count        <= '0;
                        index        <= index + 3'd1;
                        state        <= (index == 3'd7) ? STOP : DATA;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                STOP: begin
                    if (count == last_cnt) begin
                        state          <= IDLE;
                        count          <= '0;
                        o_Rx_Busy      <= 1'b0;
                        o_Rx_Valid     <= bit_s;
                        o_Rx_Frame_Err <= !bit_s;
                        if (bit_s) begin
                            o_Rx_Byte <= shreg;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    o_Rx_Busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames checked cycle by cycle against a waveform-level reference model.
module tb_uart_rx;
    localparam int P = 8;
    localparam int MID = (P - 1) / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;
    logic       rx_busy;

    int n_checks = 0;
    int n_fail = 0;

    bit         wave[$];
    logic [10:0] obs[$];

    always #5 clk = ~clk;

    uart_rx #(.p_CLKs_PB(P)) dut (
        .i_Clk(clk),
        .i_Reset(rst),
        .i_Rx_UART(rx),
        .o_Rx_Byte(rx_byte),
        .o_Rx_Valid(rx_valid),
        .o_Rx_Frame_Err(rx_err),
        .o_Rx_Busy(rx_busy)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) wave.push_back(1'b1);
    endtask

    task automatic add_low(input int n);
        for (int i = 0; i < n; i++) wave.push_back(1'b0);
    endtask

    // one 8N1 frame, P cycles per bit; goff >= 0 inverts that cycle offset of every data bit
    task automatic add_frame(input logic [7:0] b, input bit stop, input int goff);
        bit v;
        for (int k = 0; k < 10; k++) begin
            v = (k == 0) ? 1'b0 : (k == 9) ? stop : b[k-1];
            for (int c = 0; c < P; c++) wave.push_back(v ^ (k >= 1 && k <= 8 && c == goff));
        end
    endtask

    // synchronized line value the receiver acts on at edge e (two-cycle pin delay, idle-high after reset)
    function automatic bit ln(input int e);
        return (e < 2) ? 1'b1 : wave[e-2];
    endfunction

    function automatic bit smp(input int e);
`ifdef UART_RX_MAJORITY_VOTE_EN
        int s;
        s = int'(ln(e - 2)) + int'(ln(e - 1)) + int'(ln(e));
        return s >= 2;
`else
        return ln(e);
`endif
    endfunction

    // reset for one cycle, replay the waveform, then compare every cycle against the model
    task automatic play(input string tag, output int nv, output int fv);
        int n_len;
        int e;
        int m;
        int st;
        int cur;
        logic [7:0] b;
        logic [10:0] expv;
        bit bz[];
        bit er[];
        int bv[];
        rst = 1'b1;
        rx = 1'b1;
        obs.delete();
        @(negedge clk);
        rst = 1'b0;
        check({tag, "_reset"}, int'({rx_valid, rx_err, rx_busy, rx_byte}), 0);
        foreach (wave[n]) begin
            rx = wave[n];
            @(posedge clk);
            #1 obs.push_back({rx_valid, rx_err, rx_busy, rx_byte});
            @(negedge clk);
        end
        n_len = wave.size();
        bz = new[n_len];
        er = new[n_len];
        bv = new[n_len];
        foreach (bv[i]) bv[i] = -1;
        e = 1;
        while (e < n_len) begin
            if (ln(e - 1) && !ln(e)) begin
                m = e + 1 + MID;
                for (int x = e; x < m && x < n_len; x++) bz[x] = 1'b1;
                if (m >= n_len) break;
                if (ln(m)) begin
                    e = m + 1;
                    continue;
                end
                st = m + 9 * P;
                for (int x = m; x < st && x < n_len; x++) bz[x] = 1'b1;
                if (st >= n_len) break;
                for (int j = 0; j < 8; j++) b[j] = smp(m + (j + 1) * P);
                if (smp(st)) bv[st] = int'(b);
                else er[st] = 1'b1;
                e = st + 1;
            end else begin
                e++;
            end
        end
        cur = 0;
        nv = 0;
        fv = -1;
        for (int n = 0; n < n_len; n++) begin
            if (bv[n] >= 0) cur = bv[n];
            expv = {bv[n] >= 0, er[n], bz[n], 8'(cur)};
            check($sformatf("%s@%0d", tag, n), int'(obs[n]), int'(expv));
            if (obs[n][10]) begin
                if (fv < 0) fv = n;
                nv++;
            end
        end
        wave.delete();
    endtask

    initial begin
        int nv;
        int fv;
        int g;
        // single frame with the spec latency formula measured from the pin's falling edge
        add_idle(5);
        add_frame(8'hA5, 1'b1, -1);
        add_idle(2 * P);
        play("single", nv, fv);
        check("single_count", nv, 1);
        check("single_latency", fv, 5 + 3 + MID + 9 * P);
        check("single_byte", int'(rx_byte), 'hA5);
        check("single_busy_after", int'(rx_busy), 0);
        // back-to-back frames with no idle gap
        add_idle(3);
        add_frame(8'h00, 1'b1, -1);
        add_frame(8'hFF, 1'b1, -1);
        add_idle(2 * P);
        play("b2b", nv, fv);
        check("b2b_count", nv, 2);
        check("b2b_byte", int'(rx_byte), 'hFF);
        // start-bit glitch
        add_idle(4);
        add_low(2);
        add_idle(2 * P);
        play("glitch", nv, fv);
        check("glitch_count", nv, 0);
        // framing error, then a held-low line, then a good frame after the line returns high
        add_idle(3);
        add_frame(8'h11, 1'b1, -1);
        add_frame(8'h3C, 1'b0, -1);
        add_low(3 * P);
        add_idle(P);
        add_frame(8'h77, 1'b1, -1);
        add_idle(2 * P);
        play("framerr", nv, fv);
        check("framerr_count", nv, 2);
        check("framerr_byte", int'(rx_byte), 'h77);
        // abandon a frame during bit 4; the next play starts with a one-cycle reset
        add_idle(3);
        add_frame(8'h5A, 1'b1, -1);
        while (wave.size() > 3 + 5 * P + 3) void'(wave.pop_back());
        play("midframe", nv, fv);
        check("midframe_count", nv, 0);
        check("midframe_busy", int'(obs[obs.size()-1][8]), 1);
        add_idle(3);
        add_frame(8'h5A, 1'b1, -1);
        add_idle(2 * P);
        play("after_reset", nv, fv);
        check("after_reset_count", nv, 1);
        check("after_reset_byte", int'(rx_byte), 'h5A);
        // single-cycle glitches near the sample point
        add_idle(3);
        add_frame(8'hF0, 1'b1, MID);
        add_idle(2 * P);
        play("vote_early", nv, fv);
        check("vote_early_byte", int'(rx_byte), 'hF0);
        add_idle(3);
        add_frame(8'hF0, 1'b1, MID + 1);
        add_idle(2 * P);
        play("vote_late", nv, fv);
`ifdef UART_RX_MAJORITY_VOTE_EN
        check("vote_late_byte", int'(rx_byte), 'hF0);
`else
        check("vote_late_byte", int'(rx_byte), 'h0F);
`endif
        // random streams of frames, gaps, bad stop bits and glitches
        for (int it = 0; it < 8; it++) begin
            add_idle($urandom_range(1, P));
            for (int f = 0; f < 3; f++) begin
                g = $urandom_range(0, 2);
                add_frame(8'($urandom), $urandom_range(0, 4) != 0, (g == 0) ? -1 : MID + g - 1);
                add_idle($urandom_range(0, P));
            end
            add_idle(2 * P);
            play($sformatf("rand%0d", it), nv, fv);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver: 8 data bits, LSB first, 1 start bit, 1 stop bit, no parity. It is the receive-side counterpart of the team's UART transmitter and sits between the external RX pin and the byte-consuming logic. It uses the same `p_CLKs_PB` bit-period convention as the transmitter, so both ends agree at any baud rate. It delivers each received byte with a one-cycle valid strobe and flags bad stop bits.

## Interface
- `p_CLKs_PB`, default 217: clock cycles per bit. Legal range is 4..65535. The counter width is `$clog2(p_CLKs_PB)`.
- `i_Clk` input, 1 bit: the only clock. All logic is on its rising edge.
- `i_Reset` input, 1 bit: synchronous, active-high reset.
- `i_Rx_UART` input, 1 bit: asynchronous serial line. Idles high.
- `o_Rx_Byte` output, 8 bits: last correctly framed byte. Holds its value until the next good frame.
- `o_Rx_Valid` output, 1 bit: one-cycle pulse when `o_Rx_Byte` updates.
- `o_Rx_Frame_Err` output, 1 bit: one-cycle pulse when the stop bit is sampled low.
- `o_Rx_Busy` output, 1 bit: high in every state except IDLE.

## Operation
- **Input sync:** `i_Rx_UART` passes through a 2-flop synchronizer. Both flops reset to 1. A third flop holds the previous synced value for edge detection. All decisions below use the synced signal ("line").
- **IDLE:** arms only on a falling edge (previous = 1, line = 0). On that edge: go to START, count = 0, bit index = 0. A line that stays low after a frame error does not re-trigger.
- **START:** count increments each cycle. At count == (p_CLKs_PB-1)/2 (integer division):
  - line = 0: go to DATA, count = 0.
  - line = 1: treat as a glitch, go to IDLE. No output pulses.
- **DATA:** at count == p_CLKs_PB-1:
  - store the sampled bit in shift register position [index]; count = 0.
  - index 7 goes to STOP; otherwise index increments.
  - Each sample point therefore lands mid-bit.
- **STOP:** at count == p_CLKs_PB-1, sample the line, then go to IDLE on the same edge.
  - Sample = 1: `o_Rx_Byte` takes the shift register and `o_Rx_Valid` = 1 for one cycle.
  - Sample = 0: `o_Rx_Frame_Err` = 1 for one cycle and `o_Rx_Byte` is unchanged.
- **Invalid state encoding:** go to IDLE.
- **Mutual exclusion:** `o_Rx_Valid` and `o_Rx_Frame_Err` are never high in the same cycle.
- **Back-to-back frames:** a new start bit immediately after a stop bit is accepted. IDLE is re-entered about half a bit early, so the next falling edge is still caught.

## Timing
- **Reset values:** state = IDLE; `o_Rx_Byte` = 8'h00; `o_Rx_Valid` = 0; `o_Rx_Frame_Err` = 0; `o_Rx_Busy` = 0; count, index and shift register = 0; synchronizer flops = 1.
- **Reset mid-frame:** the frame is abandoned with no pulse. The receiver re-arms only on a later falling edge.
- **Sync latency:** 2 cycles from pin to line, plus 1 cycle for edge detection before START is entered.
- **Valid latency:** `o_Rx_Valid` rises about 3 + (p_CLKs_PB-1)/2 + 9·p_CLKs_PB cycles after the pin's falling edge. The exact cycle count is fixed by the rules above and is checked by the bench.
- **Busy timing:** `o_Rx_Busy` goes high the cycle after the falling edge is detected. It goes low in the same cycle as the valid or error pulse.
- **No back-pressure:** the consumer must capture `o_Rx_Byte` before the next valid pulse.

## Configuration
- Macro: `UART_RX_MAJORITY_VOTE_EN`.
- **Defined:** each data bit and the stop bit is the 2-of-3 majority of line samples at counts p_CLKs_PB-3, p_CLKs_PB-2 and p_CLKs_PB-1. The decision is made at p_CLKs_PB-1. The start-bit check stays a single sample. Requires p_CLKs_PB ≥ 4.
- **Undefined:** single sample at count p_CLKs_PB-1. No vote registers are built.
- All timing and interface behaviour is identical in both builds.

## Test plan
- **Single frame:** p_CLKs_PB=8; send 8'hA5 with a good stop bit → exactly one `o_Rx_Valid` pulse, `o_Rx_Byte`=8'hA5, `o_Rx_Frame_Err` never high, `o_Rx_Busy` low afterwards.
- **Back-to-back:** send 8'h00 then 8'hFF with zero idle gap → two valid pulses, bytes 8'h00 then 8'hFF.
- **Start glitch:** line low for 2 cycles then high → no pulses; `o_Rx_Busy` drops back to 0 within p_CLKs_PB/2+4 cycles.
- **Framing error:** send 8'h3C with the stop bit held low, after a prior good 8'h11 → one `o_Rx_Frame_Err` pulse, no valid pulse, `o_Rx_Byte` stays 8'h11. A line held low afterwards produces no new frame until it goes high and then falls.
- **Reset mid-frame:** assert `i_Reset` for 1 cycle during bit 4 → all outputs at reset values with no pulses. A following 8'h5A frame is received correctly.
- **Majority vote:** `UART_RX_MAJORITY_VOTE_EN` defined; send 8'hF0 with a 1-cycle inverted glitch at count p_CLKs_PB-2 of every bit → byte 8'hF0 received. Without the macro and with the glitch moved to count p_CLKs_PB-1, the affected bits flip.
